// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier: WIDTH iterations per product,
// start/done handshake shared with the restoring divider.
module booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inbus1,
  input  logic [WIDTH-1:0] inbus2,
  output logic [WIDTH-1:0] outbus_hi,
  output logic [WIDTH-1:0] outbus_lo,
  output logic             busy,
  output logic             done,
  output logic             ovr
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             ovr_q, ovr_d, busy_q, busy_d, done_q, done_d;

  // One Booth step: conditional add/sub, then arithmetic shift of {A,Q,q_m1}
  logic [WIDTH:0]     sum, a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     top;

  always_comb begin
    sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh = {sum[0], q_q[WIDTH-1:1]};
    prod = {a_sh[WIDTH-1:0], q_sh};
    top  = prod[2*WIDTH-1:WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          ovr_d   = ~((&top) | ~(|top));
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A start in FIN is accepted; the finishing done pulse is already on the outputs
    if (start && (state_q == IDLE || state_q == FIN)) begin
      state_d = RUN;
      m_d     = {inbus1[WIDTH-1], inbus1};
      a_d     = '0;
      q_d     = inbus2;
      qm1_d   = 1'b0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign outbus_hi = hi_q;
  assign outbus_lo = lo_q;
  assign ovr       = ovr_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_booth_mult.sv
// Directed + random check of booth_mult against integer multiplication.
module tb_booth_mult;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] inbus1 = '0, inbus2 = '0;
  logic [7:0] outbus_hi, outbus_lo;
  logic       busy, done, ovr;
  int         nvec = 0, nerr = 0;

  booth_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .inbus1(inbus1), .inbus2(inbus2),
    .outbus_hi(outbus_hi), .outbus_lo(outbus_lo), .busy(busy), .done(done), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic logic ref_ovr(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return (p > 127) || (p < -128);
  endfunction

  // Wait for done counting cycles after the start edge (cycle 1 follows it)
  task automatic wait_done(input string tag, output int k, output int nb);
    k = 1; nb = 0;
    while (!done && k < 30) begin
      if (busy) nb++;
      tick();
      k++;
    end
    chk({tag, " latency"}, k, 9);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    int k, nb;
    inbus1 = a; inbus2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    inbus1 = 8'($urandom); inbus2 = 8'($urandom);
    wait_done(tag, k, nb);
    chk({tag, " busy cycles"}, nb, 8);
    chk({tag, " busy in done"}, busy, 0);
    chk({tag, " product"}, {outbus_hi, outbus_lo}, ref_prod(a, b));
    chk({tag, " ovr"}, ovr, ref_ovr(a, b));
    tick();
    chk({tag, " done single"}, done, 0);
  endtask

  initial begin
    int k, nb, held_bad, seen;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst ovr", ovr, 0);
    chk("rst out", {outbus_hi, outbus_lo}, 0);
    rst = 1'b1;
    tick();

    do_op(8'd5, 8'd3, "5x3");
    chk("5x3 exact", {outbus_hi, outbus_lo}, 16'h000F);
    do_op(8'hF9, 8'd6, "-7x6");
    chk("-7x6 exact", {outbus_hi, outbus_lo}, 16'hFFD6);
    do_op(8'd127, 8'hFF, "127x-1");
    chk("127x-1 exact", {outbus_hi, outbus_lo}, 16'hFF81);
    do_op(8'h80, 8'h80, "-128x-128");
    chk("-128x-128 exact", {outbus_hi, outbus_lo, 7'd0, ovr}, {16'h4000, 8'h01});
    do_op(8'h80, 8'd1, "-128x1");
    chk("-128x1 exact", {outbus_hi, outbus_lo, 7'd0, ovr}, {16'hFF80, 8'h00});

    // Start during RUN is ignored; start during done is accepted
    inbus1 = 8'd5; inbus2 = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    inbus1 = 8'd2; inbus2 = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    k = 5; nb = 0;
    while (!done && k < 30) begin tick(); k++; end
    chk("ign latency", k, 9);
    chk("ign product", {outbus_hi, outbus_lo}, 16'h000F);
    inbus1 = 8'd2; inbus2 = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    held_bad = 0;
    k = 1;
    while (!done && k < 30) begin
      if ({outbus_hi, outbus_lo} !== 16'h000F) held_bad++;
      tick();
      k++;
    end
    chk("b2b latency", k, 9);
    chk("b2b hold", held_bad, 0);
    chk("b2b product", {outbus_hi, outbus_lo}, 16'h0004);
    tick();

    // Async reset mid-operation
    inbus1 = 8'd100; inbus2 = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort ovr", ovr, 0);
    chk("abort out", {outbus_hi, outbus_lo}, 0);
    tick();
    rst = 1'b1;
    seen = 0;
    repeat (15) begin tick(); if (done) seen++; end
    chk("abort no done", seen, 0);
    do_op(8'd0, 8'hD3, "0x-45");
    chk("0x-45 exact", {outbus_hi, outbus_lo, 7'd0, ovr}, {16'h0000, 8'h00});

    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom), 8'($urandom), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/booth_mult.md
Name: booth_mult

Overview:
- Sequential signed multiplier using radix-2 Booth recoding. Companion to the team's restoring divider, performing the inverse operation.
- Takes two two's-complement operands and produces a double-width two's-complement product after WIDTH iteration cycles.
- Uses the same start/done handshake as the divider, so the top-level operation selector drives both blocks identically.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  clock, rising edge active
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; operands sampled on the same edge
inbus1  input  WIDTH  multiplicand M, two's complement
inbus2  input  WIDTH  multiplier Q, two's complement
outbus_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
outbus_lo  output  WIDTH  product bits [WIDTH-1:0]
busy  output  1  high while iterating
done  output  1  one-cycle pulse when the product is valid
ovr  output  1  product does not fit in WIDTH-bit signed; valid with done

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; accumulator A, Q, q_m1 and count cleared.
  - busy=0, done=0, ovr=0, outbus_hi=0, outbus_lo=0.
  - Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge E0:
  - M <= inbus1, sign-extended to WIDTH+1 bits.
  - A <= 0 (WIDTH+1 bits); Q <= inbus2; q_m1 <= 0; count <= 0.
  - Go to RUN; busy=1 from E0.
- RUN, one iteration per edge, by {Q[0], q_m1}:
  - 01: A += M.
  - 10: A -= M.
  - 00 / 11: no add.
  - Then arithmetic shift right of {A, Q, q_m1} by 1, replicating A's MSB.
  - count increments each iteration; after WIDTH iterations (edge E_WIDTH) go to FIN.
- Accumulator width:
  - A is WIDTH+1 bits, so M = -2^(WIDTH-1) never overflows on subtract.
  - Product = {A[WIDTH-1:0], Q}.
- FIN (one cycle):
  - done=1, busy=0.
  - outbus_hi/outbus_lo registered with the product.
  - ovr=1 iff product bits [2*WIDTH-1:WIDTH-1] are not all equal.
  - Next edge returns to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH (WIDTH+1 edges after the start edge; 9 for WIDTH=8).
- Output hold: outbus_hi, outbus_lo and ovr hold their values until the next FIN; they do not change during a subsequent RUN.
- start while in RUN: ignored; the operation in progress is unaffected.
- start while in FIN: accepted. Operands are loaded, the next state is RUN, and the done pulse of the finishing operation still occurs.
- Operand changes after the start edge have no effect.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then start with inbus1=5, inbus2=3 -> done exactly 9 cycles after start edge; outbus_hi=0x00, outbus_lo=0x0F, ovr=0; busy high for cycles 1-8 only.
- inbus1=-7 (0xF9), inbus2=6 -> {hi,lo}=0xFFD6 (-42), ovr=0. Also inbus1=127, inbus2=-1 -> 0xFF81, ovr=0.
- inbus1=-128, inbus2=-128 -> 0x4000, ovr=1. Also inbus1=-128, inbus2=1 -> 0xFF80, ovr=0.
- Start 5*3; pulse start with 2*2 at cycle 4 -> ignored, result 0x000F. Then start 2*2 in the done cycle -> second done 9 cycles later with 0x0004; first result held until then.
- Start 100*100; drop rst at cycle 5 -> all outputs 0 immediately, no done. After release, 0*(-45) -> 0x0000, ovr=0.
- Randomised: 1000 random signed pairs checked against a reference product and ovr -> exact match, done exactly once per accepted start.
